// File: rtl/sd_pkg.sv
// Shared constants and types for the 64-bit scoreboard memory.
// Holds the request encoding, line width, response-buffer states and the masked-merge helper.
package sd_pkg;

  localparam int LINE_W = 64;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef logic [LINE_W-1:0] line_t;

  // Bits set in mask take the new data; all other bits keep the old line.
  function automatic line_t merge_line(line_t old_line, line_t new_data, line_t mask);
    return (old_line & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/sd_ram64.sv
// One-read/one-write synchronous line array with a bit-masked write and a registered read.
// The read register only loads when rd_en is high, so it holds a line across response stalls.
module sd_ram64
  import sd_pkg::*;
#(
  parameter int s_asz = 11
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [s_asz-1:0] wr_addr,
  input  line_t            wr_mask,
  input  line_t            wr_data,
  input  logic             rd_en,
  input  logic [s_asz-1:0] rd_addr,
  output line_t            rd_data
);

  line_t mem [2**s_asz];
  line_t rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= merge_line(mem[wr_addr], wr_data, wr_mask);
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sd_mem64.sv
// Scoreboard line memory: a single request channel (masked writes, reads) feeding
// a one-entry read-response buffer, plus wrapping read and write transfer counters.
module sd_mem64
  import sd_pkg::*;
#(
  parameter int s_asz = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              z2s_srdy,
  output logic              z2s_drdy,
  input  logic              z2s_req_type,
  input  logic [LINE_W-1:0] z2s_mask,
  input  logic [LINE_W-1:0] z2s_data,
  input  logic [s_asz-1:0]  z2s_itemid,
  output logic              s2z_srdy,
  input  logic              s2z_drdy,
  output logic [LINE_W-1:0] s2z_data,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  logic [0:0]  state_reg, state_next;
  logic        rd_xfer, wr_xfer, resp_xfer;
  line_t       ram_rd_data;
  logic [15:0] rd_cnt_reg, wr_cnt_reg;

  assign s2z_srdy = (state_reg == ST_FULL);

  // Writes never touch the response buffer, so they are always taken.
  assign z2s_drdy = (z2s_req_type == REQ_WR) ? 1'b1 : (!s2z_srdy || s2z_drdy);

  assign rd_xfer   = z2s_srdy && z2s_drdy && (z2s_req_type == REQ_RD);
  assign wr_xfer   = z2s_srdy && z2s_drdy && (z2s_req_type == REQ_WR);
  assign resp_xfer = s2z_srdy && s2z_drdy;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (rd_xfer) state_next = ST_FULL;
      default:  if (resp_xfer && !rd_xfer) state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_EMPTY;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (rd_xfer) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      if (wr_xfer) wr_cnt_reg <= wr_cnt_reg + 16'd1;
    end
  end

  sd_ram64 #(
    .s_asz (s_asz)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_xfer),
    .wr_addr (z2s_itemid),
    .wr_mask (z2s_mask),
    .wr_data (z2s_data),
    .rd_en   (rd_xfer),
    .rd_addr (z2s_itemid),
    .rd_data (ram_rd_data)
  );

  // The array has no reset, so the line is gated by the buffer state to give zero while empty.
  assign s2z_data = s2z_srdy ? ram_rd_data : '0;
  assign rd_cnt   = rd_cnt_reg;
  assign wr_cnt   = wr_cnt_reg;

endmodule

// File: tb/tb_sd_mem64.sv
// Randomized and directed bench for sd_mem64 against a line-array / response-queue model.
module tb_sd_mem64;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          z2s_srdy, z2s_drdy, z2s_req_type;
  logic [63:0]   z2s_mask, z2s_data;
  logic [AW-1:0] z2s_itemid;
  logic          s2z_srdy, s2z_drdy;
  logic [63:0]   s2z_data;
  logic [15:0]   rd_cnt, wr_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] resp_q [$];
  int          m_rd = 0;
  int          m_wr = 0;
  logic        last_acc;
  logic [63:0] saved;

  always #5 clk = ~clk;

  sd_mem64 #(.s_asz(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .z2s_srdy     (z2s_srdy),
    .z2s_drdy     (z2s_drdy),
    .z2s_req_type (z2s_req_type),
    .z2s_mask     (z2s_mask),
    .z2s_data     (z2s_data),
    .z2s_itemid   (z2s_itemid),
    .s2z_srdy     (s2z_srdy),
    .s2z_drdy     (s2z_drdy),
    .s2z_data     (s2z_data),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock of traffic: drive at negedge, check settled outputs, then advance the model at posedge.
  task automatic step(input logic srdy, input logic typ, input logic [AW-1:0] addr,
                      input logic [63:0] mask, input logic [63:0] data, input logic rdrdy);
    logic exp_drdy, rd_x, wr_x, rsp_x;
    @(negedge clk);
    z2s_srdy     = srdy;
    z2s_req_type = typ;
    z2s_itemid   = addr;
    z2s_mask     = mask;
    z2s_data     = data;
    s2z_drdy     = rdrdy;
    #1;
    // A read needs the response slot free, or freed by this cycle's consumption.
    exp_drdy = typ || (resp_q.size() == 0) || rdrdy;
    chk("z2s_drdy", 64'(z2s_drdy), 64'(exp_drdy));
    chk("s2z_srdy", 64'(s2z_srdy), 64'(resp_q.size() != 0));
    if (resp_q.size() != 0) chk("s2z_data", s2z_data, resp_q[0]);
    chk("rd_cnt", 64'(rd_cnt), 64'(m_rd % 65536));
    chk("wr_cnt", 64'(wr_cnt), 64'(m_wr % 65536));
    rsp_x    = (resp_q.size() != 0) && rdrdy;
    rd_x     = srdy && !typ && exp_drdy;
    wr_x     = srdy && typ;
    last_acc = rd_x || wr_x;
    @(posedge clk);
    if (rsp_x) void'(resp_q.pop_front());
    if (rd_x) begin
      resp_q.push_back(ref_mem[addr]);
      m_rd++;
    end
    if (wr_x) begin
      for (int b = 0; b < 64; b++) if (mask[b]) ref_mem[addr][b] = data[b];
      m_wr++;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] m, input logic [63:0] d, input logic rdrdy);
    step(1'b1, 1'b1, a, m, d, rdrdy);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rdrdy);
    step(1'b1, 1'b0, a, rnd64(), rnd64(), rdrdy);
  endtask

  task automatic idle(input logic rdrdy);
    step(1'b0, 1'($urandom), AW'($urandom), rnd64(), rnd64(), rdrdy);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    z2s_srdy = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_srdy", 64'(s2z_srdy), 64'd0);
    chk("rst_data", s2z_data, 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    resp_q.delete();
    m_rd = 0;
    m_wr = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; z2s_srdy = 1'b0; z2s_req_type = 1'b0; s2z_drdy = 1'b0;
    z2s_mask = '0; z2s_data = '0; z2s_itemid = '0;
    #13;
    chk("init_srdy", 64'(s2z_srdy), 64'd0);
    chk("init_data", s2z_data, 64'd0);
    chk("init_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("init_wr_cnt", 64'(wr_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), '1, rnd64(), 1'b1);

    // Masked write over a zero line, then read it back.
    wr(5, '1, 64'h0, 1'b1);
    wr(5, 64'hFF00_0000_0000_0000, {8{8'hA5}}, 1'b1);
    rd(5, 1'b1);
    #1 chk("req032_data", s2z_data, 64'hA500_0000_0000_0000);
    idle(1'b1);

    // Mask 0 write: no change, still counted.
    saved = ref_mem[9];
    wr(9, 64'h0, rnd64(), 1'b1);
    rd(9, 1'b1);
    #1 chk("mask0_data", s2z_data, saved);
    idle(1'b1);

    // Back-to-back reads with the consumer always ready.
    rd(1, 1'b1); rd(2, 1'b1); rd(3, 1'b1);
    idle(1'b1);

    // Stalled response blocks the next read for four cycles.
    rd(4, 1'b0);
    for (int i = 0; i < 4; i++) rd(6, 1'b0);
    rd(6, 1'b1);
    chk("req034_acc", 64'(last_acc), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Write the same line while its read response is stalled.
    rd(7, 1'b0);
    saved = ref_mem[7];
    wr(7, '1, 64'h1, 1'b0);
    chk("req035_acc", 64'(last_acc), 64'd1);
    #1 chk("req035_stall", s2z_data, saved);
    idle(1'b1);
    rd(7, 1'b1);
    #1 chk("req035_new", s2z_data, 64'h1);
    idle(1'b1);

    // Reset while a response is pending; array survives.
    rd(3, 1'b0);
    #1 chk("pre_rst_srdy", 64'(s2z_srdy), 64'd1);
    pulse_reset();
    idle(1'b1);
    rd(5, 1'b1);
    #1 chk("post_rst_data", s2z_data, 64'hA500_0000_0000_0000);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) idle(1'($urandom_range(3) != 0));
      else if ($urandom_range(1) == 0) rd(AW'($urandom), 1'($urandom_range(3) != 0));
      else wr(AW'($urandom), rnd64(), rnd64(), 1'($urandom_range(3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    // Write counter wrap.
    pulse_reset();
    for (int i = 0; i < 65537; i++) wr(AW'($urandom), rnd64(), rnd64(), 1'b1);
    #1 chk("wr_cnt_wrap", 64'(wr_cnt), 64'd1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_mem64.md
SD_MEM64 -- requirements
Module: sd_mem64

Interface
REQ-001 SHALL have parameter s_asz, default 11, scoreboard item-address width; array depth is 2**s_asz lines of 64 bits.
REQ-002 SHALL have port clk, input, 1, single clock; all flops are rising-edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port z2s_srdy, input, 1, request valid.
REQ-005 SHALL have port z2s_drdy, output, 1, request accepted this cycle when high with z2s_srdy.
REQ-006 SHALL have port z2s_req_type, input, 1, request type: 0=read, 1=write.
REQ-007 SHALL have port z2s_mask, input, 64, bitwise write enable.
REQ-008 SHALL have port z2s_data, input, 64, write data.
REQ-009 SHALL have port z2s_itemid, input, s_asz, line address.
REQ-010 SHALL have port s2z_srdy, output, 1, read response valid.
REQ-011 SHALL have port s2z_drdy, input, 1, response consumed when high with s2z_srdy.
REQ-012 SHALL have port s2z_data, output, 64, read response line.
REQ-013 SHALL have port rd_cnt, output, 16, count of accepted reads.
REQ-014 SHALL have port wr_cnt, output, 16, count of accepted writes.

Function
REQ-015 SHALL define transfer as srdy&drdy sampled high at a rising clk edge, on both channels.
REQ-016 SHALL drive z2s_drdy = 1 when z2s_req_type=1, else (!s2z_srdy | s2z_drdy); purely combinational.
REQ-017 SHALL, on write transfer at edge N, update the line at itemid to (old & ~mask) | (data & mask) at edge N; no response generated.
REQ-018 SHALL treat mask 64'h0 write as no array change, still counted in wr_cnt.
REQ-019 SHALL, on read transfer at edge N, set s2z_srdy=1 and s2z_data=line[itemid] after edge N (latency 1 cycle).
REQ-020 SHALL return data including all writes transferred at or before edge N-1 (read-after-write with no bubble).
REQ-021 SHALL hold s2z_srdy and s2z_data stable while s2z_srdy & !s2z_drdy.
REQ-022 SHALL clear s2z_srdy after a response transfer unless a new read transfers at the same edge, in which case s2z_srdy stays 1 and s2z_data loads the new line (back-to-back reads, one per cycle).
REQ-023 SHALL accept writes while a read response is stalled; the stalled s2z_data is unaffected even if the same itemid is written.
REQ-024 SHALL have response-buffer states EMPTY (s2z_srdy=0) and FULL (s2z_srdy=1): EMPTY->FULL on read transfer; FULL->EMPTY on response transfer with no read; FULL->FULL otherwise.
REQ-025 SHALL increment rd_cnt/wr_cnt by 1 per respective transfer, wrapping 16'hFFFF->16'h0000.
REQ-026 SHALL ignore z2s_mask/z2s_data/z2s_itemid when z2s_srdy=0; no X propagation from these to outputs.

Reset
REQ-027 SHALL, while reset_n=0, force s2z_srdy=0, s2z_data=64'h0, rd_cnt=0, wr_cnt=0 immediately (asynchronously).
REQ-028 SHALL leave array contents unchanged by reset; contents are undefined after power-up.
REQ-029 SHALL drop any pending read response on reset mid-operation; no response is reissued after deassertion.

Structure
REQ-030 SHALL place request-type constants (REQ_RD=0, REQ_WR=1) and line width 64 in shared package sd_pkg.
REQ-031 SHALL instantiate one sub-module sd_ram64: 1 read/1 write synchronous array, s_asz address, 64-bit bit-masked write, registered read; no reset.

Verification
REQ-032 SHALL cover write itemid=5, mask=64'hFF00_0000_0000_0000, data={8{8'hA5}} over line 0, then read 5 -> s2z_data=64'hA500_0000_0000_0000 one cycle after accept.
REQ-033 SHALL cover back-to-back reads of items 1,2,3 with s2z_drdy=1 constantly -> three consecutive response cycles, data in order, z2s_drdy never low.
REQ-034 SHALL cover a read with s2z_drdy=0 for 4 cycles, then a second read request -> z2s_drdy=0 for those 4 cycles, data stable, second read accepted the cycle s2z_drdy rises.
REQ-035 SHALL cover a read of item 7 stalled, then write item 7 with full mask, data 64'h1 -> write accepted, stalled s2z_data keeps old value, later read returns 64'h1.
REQ-036 SHALL cover reset_n pulsed low while s2z_srdy=1 -> s2z_srdy=0 and counters 0 without clock edge; after reset, array data written earlier still readable.
REQ-037 SHALL cover 65537 writes -> wr_cnt=1 (wrap).
